// File: rtl/rx_frame_parser.sv
// Receive-side frame parser: hunts for a sync header, streams payload through a
// 2-entry skid buffer, verifies the trailing checksum and keeps saturating stats.
module rx_frame_parser #(
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int unsigned MAX_LEN   = 1024
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [15:0] MAX_LEN_W = MAX_LEN[15:0];

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_e;

  state_e      state_q, state_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  occ_q, occ_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] sum_q, sum_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [31:0] buf_data_q [2];
  logic [31:0] buf_data_d [2];
  logic        buf_last_q [2];
  logic        buf_last_d [2];

  logic        accept;
  logic        push;
  logic        push_last;
  logic        pop;
  logic [2:0]  credit_need;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A read is only ever outstanding for one cycle, so reserving a slot for it
  // plus the one about to be requested keeps the buffer from overflowing.
  assign credit_need = {1'b0, occ_q} + {2'b00, inflight_q} + 3'd1;
  assign rx_ready    = rst && (credit_need <= 3'd2);

  // Words with no matching request (e.g. right after reset) are stale.
  assign accept    = rx_valid && inflight_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_last  = buf_last_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    push        = 1'b0;
    push_last   = 1'b0;

    case (state_q)
      HUNT: begin
        if (accept) begin
          if (rx_data[31:16] != SYNC_WORD) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else if (rx_data[15:0] > MAX_LEN_W) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
            err_cnt_d   = sat_inc(err_cnt_q);
          end else if (rx_data[15:0] == 16'd0) begin
            sum_d   = 32'd0;
            state_d = CHECK;
          end else begin
            remaining_d = rx_data[15:0];
            sum_d       = 32'd0;
            state_d     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          push        = 1'b1;
          sum_d       = sum_q + rx_data;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            push_last = 1'b1;
            state_d   = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            frame_ok_d  = 1'b1;
            frame_cnt_d = sat_inc(frame_cnt_q);
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
            err_cnt_d   = sat_inc(err_cnt_q);
          end
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    inflight_d = rx_ready;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
      always_comb begin
        buf_data_d[gi] = buf_data_q[gi];
        buf_last_d[gi] = buf_last_q[gi];
        if (push && (wr_ptr_q == 1'(gi))) begin
          buf_data_d[gi] = rx_data;
          buf_last_d[gi] = push_last;
        end
      end

      always_ff @(posedge rx_clk) begin
        if (!rst) begin
          buf_data_q[gi] <= 32'd0;
          buf_last_q[gi] <= 1'b0;
        end else begin
          buf_data_q[gi] <= buf_data_d[gi];
          buf_last_q[gi] <= buf_last_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge rx_clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      remaining_q <= 16'd0;
      sum_q       <= 32'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
